// File: rtl/ucode_loader.sv
// ucode_loader: write-side front end of the 256x24 microprogram control store.
// Takes a byte stream over a valid/ready handshake, packs each BYTES-byte group
// (most significant byte first) into one microword and strobes it into the
// control-store write port at an auto-incrementing address. The read port stays
// with the microsequencer; this block only ever drives the write side.
//
// All outputs are registered. The handshake/strobe flags are registered from the
// next-state decode, so they line up exactly with the state they describe.
module ucode_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 24,   // must equal 8*BYTES
    parameter int BYTES  = 3
) (
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    // Byte counter only needs to reach BYTES-1 before it wraps back to zero.
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]  WORD_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] byte_cnt;
    logic [ADDR_W:0]  len_q;
    logic             byte_xfer;
    logic             word_full;
    logic             last_word;

    // A byte is consumed only in COLLECT, and never in a cycle that is being
    // aborted: abort wins over a simultaneous transfer.
    assign byte_xfer = (state == S_COLLECT) && byte_valid && byte_ready && !abort;
    assign word_full = byte_xfer && (byte_cnt == LAST_BYTE);
    // Compared against the pre-increment count so the decision is made in the
    // WRITE cycle itself.
    assign last_word = ((words_written + WORD_ONE) == len_q);

    // State register; reset drops straight back to IDLE, killing any load.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: start only matters in IDLE, abort only in COLLECT/WRITE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (word_full) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_word) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_COLLECT;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered status/strobe flags, derived from where the FSM is heading so
    // they are valid for the whole cycle spent in that state.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            byte_ready <= 1'b0;
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            byte_ready <= (state_next == S_COLLECT);
            we         <= (state_next == S_WRITE);
            busy       <= (state_next == S_COLLECT) || (state_next == S_WRITE);
            done       <= (state_next == S_DONE);
        end
    end

    // Datapath: address/length capture, byte assembly and write bookkeeping.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            waddr         <= '0;
            wdata         <= '0;
            words_written <= '0;
            len_q         <= '0;
            byte_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        waddr         <= start_addr;
                        len_q         <= len;
                        words_written <= '0;
                        byte_cnt      <= '0;
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        // Partial word is dropped; the next load starts from byte 0.
                        byte_cnt <= '0;
                    end else if (byte_xfer) begin
                        wdata    <= {wdata[WORD_W-9:0], byte_in};
                        byte_cnt <= word_full ? '0 : (byte_cnt + CNT_ONE);
                    end
                end
                S_WRITE: begin
                    // The strobe is already out this cycle, so the word counts as
                    // written even if abort arrives alongside it. Address wraps
                    // naturally modulo 2^ADDR_W.
                    waddr         <= waddr + ADDR_ONE;
                    words_written <= words_written + WORD_ONE;
                end
                default: begin
                    byte_cnt <= byte_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_loader.sv
// Self-checking bench for ucode_loader: randomized and directed byte-stream
// loads against a word-level reference model, with a scoreboard monitor that
// checks every control-store write as it appears.
module tb_ucode_loader;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 24;
    localparam int BYTES  = 3;

    logic              CLK = 1'b0;
    logic              CLR_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              abort = 1'b0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;

    ucode_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BYTES(BYTES)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .start(start), .start_addr(start_addr),
        .len(len), .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .words_written(words_written)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int cyc = 0;
    int last_we = -1;
    bit gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe is matched against the model queue.
    always @(negedge CLK) begin
        wr_t e;
        cyc++;
        if (CLR_n) begin
            if (done) done_cnt++;
            if (we) begin
                we_cnt++;
                chk("we_with_ready", {31'd0, byte_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: waddr 0x%0h wdata 0x%0h, no write expected", waddr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("waddr", {24'd0, waddr}, {24'd0, e.addr});
                    chk("wdata", {8'd0, wdata}, {8'd0, e.data});
                end
                if (gap_chk && last_we >= 0) chk("we_gap", cyc - last_we, BYTES + 1);
                last_we = cyc;
            end
            if (!busy) last_we = -1;
        end
    end

    // Drive nbytes stream bytes; mode 0 = always valid, 1 = every other cycle, 2 = random.
    task automatic stream(input int nbytes, input int mode, input bit ign_start, output int sent);
        int  budget;
        int  iter;
        bit  v;
        bit  xfer;
        sent = 0;
        iter = 0;
        budget = nbytes * 8 + 50;
        while (sent < nbytes && budget > 0) begin
            @(negedge CLK);
            case (mode)
                0:       v = 1'b1;
                1:       v = (iter % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v;
            byte_in = stim_q[sent];
            if (ign_start && sent == 2) begin
                start = 1'b1;
                start_addr = 8'h55;
                len = 9'd7;
            end else begin
                start = 1'b0;
            end
            xfer = v && byte_ready;
            @(posedge CLK);
            if (xfer) sent++;
            budget--;
            iter++;
        end
        if (sent < nbytes) chk("stream_timeout", sent, nbytes);
    endtask

    // One load: action 0 = complete, 1 = abort after stop_at bytes, 2 = async reset after stop_at bytes.
    task automatic run_load(input logic [7:0] sa, input int n, input int stop_at, input int action,
                            input int mode, input bit ign_start);
        int nb;
        int stop;
        int completed;
        int d0;
        int w0;
        int wb;
        int sent;
        int budget;
        nb = n * BYTES;
        stop = (action == 0) ? nb : stop_at;
        completed = (action == 0) ? n : stop_at / BYTES;
        while (stim_q.size() < nb) stim_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < completed; i++)
            exp_q.push_back({8'(sa + i), stim_q[3*i], stim_q[3*i+1], stim_q[3*i+2]});
        gap_chk = (mode == 0);
        d0 = done_cnt;
        w0 = we_cnt;
        @(negedge CLK);
        start = 1'b1;
        start_addr = sa;
        len = 9'(n);
        @(negedge CLK);
        start = 1'b0;
        stream(stop, mode, ign_start, sent);
        if (action == 2) begin
            #2;
            CLR_n = 1'b0;
            byte_valid = 1'b0;
            wb = we_cnt;
            #1;
            chk("rst_byte_ready", {31'd0, byte_ready}, 0);
            chk("rst_we", {31'd0, we}, 0);
            chk("rst_waddr", {24'd0, waddr}, 0);
            chk("rst_wdata", {8'd0, wdata}, 0);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_done", {31'd0, done}, 0);
            chk("rst_words_written", {23'd0, words_written}, 0);
            @(negedge CLK);
            #2;
            CLR_n = 1'b1;
            repeat (10) @(negedge CLK);
            chk("writes_before_reset", wb - w0, completed);
            chk("no_we_after_reset", we_cnt, wb);
            chk("idle_after_reset", {31'd0, busy}, 0);
            chk("waddr_after_reset", {24'd0, waddr}, 0);
        end else begin
            @(negedge CLK);
            byte_valid = 1'b0;
            if (action == 1) begin
                abort = 1'b1;
                @(negedge CLK);
                abort = 1'b0;
            end
            budget = 40;
            while (budget > 0 && !(exp_q.size() == 0 && (action != 0 || done_cnt != d0))) begin
                @(negedge CLK);
                budget--;
            end
            if (budget == 0) chk("load_timeout", 1, 0);
            repeat (3) @(negedge CLK);
            chk("done_count", done_cnt - d0, (action == 0) ? 1 : 0);
            chk("write_count", we_cnt - w0, completed);
            chk("words_written", {23'd0, words_written}, completed);
            chk("waddr_final", {24'd0, waddr}, {24'd0, 8'(sa + completed)});
            chk("busy_idle", {31'd0, busy}, 0);
        end
        chk("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
        stim_q.delete();
        gap_chk = 1'b0;
    endtask

    // Stimulus: reset, directed scenarios, then randomized loads.
    initial begin
        int n;
        int stop;
        #12;
        chk("reset_byte_ready", {31'd0, byte_ready}, 0);
        chk("reset_we", {31'd0, we}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_waddr", {24'd0, waddr}, 0);
        chk("reset_wdata", {8'd0, wdata}, 0);
        chk("reset_words_written", {23'd0, words_written}, 0);
        #10;
        CLR_n = 1'b1;
        repeat (2) @(negedge CLK);

        stim_q = '{8'h12, 8'h34, 8'h56};
        run_load(8'h10, 1, 0, 0, 0, 1'b0);

        stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        run_load(8'h00, 2, 0, 0, 1, 1'b0);

        run_load(8'hFE, 3, 0, 0, 2, 1'b0);

        run_load(8'h33, 0, 0, 0, 0, 1'b0);

        run_load(8'h40, 2, 0, 0, 0, 1'b1);

        run_load(8'h20, 4, 5, 1, 0, 1'b0);
        stim_q = '{8'hC3, 8'h5A, 8'h0F};
        run_load(8'h90, 1, 0, 0, 1, 1'b0);

        run_load(8'h80, 256, 0, 0, 0, 1'b0);

        run_load(8'h70, 3, 4, 2, 0, 1'b0);
        run_load(8'h08, 2, 0, 0, 2, 1'b0);

        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) begin
                stop = $urandom_range(1, n * BYTES - 1);
                if (stop % BYTES == 0) stop = stop - 1;
                run_load(8'($urandom_range(0, 255)), n, stop, 1, $urandom_range(0, 2), 1'b0);
            end else begin
                run_load(8'($urandom_range(0, 255)), n, 0, 0, $urandom_range(0, 2), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
